// File: rtl/lsu_stage.sv
// lsu_stage: single-outstanding load/store stage between the ALU and memory.
// One operation at a time: IDLE -> REQ -> (WAIT) -> DONE -> IDLE.
// Optional build macro LSU_MISALIGN_CHECK_EN: misaligned accesses skip memory
// and complete immediately with out_misalign=1 and out_rdata=0.
module lsu_stage #(
  parameter int unsigned XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] addr,
  input  logic [XLEN-1:0] wdata,
  input  logic            is_load,
  input  logic            is_store,
  input  logic [1:0]      size,
  input  logic            load_unsigned,
  output logic            mem_req_valid,
  input  logic            mem_req_ready,
  output logic [XLEN-1:0] mem_req_addr,
  output logic            mem_req_wen,
  output logic [XLEN-1:0] mem_req_wdata,
  output logic [7:0]      mem_req_wmask,
  input  logic            mem_resp_valid,
  input  logic [XLEN-1:0] mem_resp_rdata,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_rdata,
  output logic            out_misalign
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, stateNext;

  logic [XLEN-1:0] addrQ;
  logic [XLEN-1:0] wdataQ;
  logic [XLEN-1:0] rdataQ;
  logic [7:0]      wmaskQ;
  logic            isStoreQ;
  logic [1:0]      sizeQ;
  logic            unsignedQ;

  logic [7:0]      baseMask;
  logic [14:0]     maskWide;
  logic [XLEN-1:0] storeData;
  logic [XLEN-1:0] respShifted;
  logic [XLEN-1:0] loadData;
  logic            misalignHit;

`ifdef LSU_MISALIGN_CHECK_EN
  logic misalignQ;

  // An access is misaligned when addr is not a multiple of its byte size
  always_comb begin
    misalignHit = 1'b0;
    if (is_load || is_store) begin
      case (size)
        2'd0:    misalignHit = 1'b0;
        2'd1:    misalignHit = addr[0];
        2'd2:    misalignHit = |addr[1:0];
        default: misalignHit = |addr[2:0];
      endcase
    end
  end

  assign out_misalign = misalignQ;
`else
  assign misalignHit  = 1'b0;
  assign out_misalign = 1'b0;
`endif

  // Store byte lanes and data aligned to the doubleword; lanes past bit 7 drop
  always_comb begin
    case (size)
      2'd0:    baseMask = 8'h01;
      2'd1:    baseMask = 8'h03;
      2'd2:    baseMask = 8'h0F;
      default: baseMask = 8'hFF;
    endcase
    maskWide  = {7'b0, baseMask} << addr[2:0];
    storeData = wdata << {addr[2:0], 3'b000};
  end

  // Load extraction: align the addressed bytes down, then sign/zero-extend
  always_comb begin
    respShifted = mem_resp_rdata >> {addrQ[2:0], 3'b000};
    case (sizeQ)
      2'd0:    loadData = {{(XLEN-8){~unsignedQ & respShifted[7]}},   respShifted[7:0]};
      2'd1:    loadData = {{(XLEN-16){~unsignedQ & respShifted[15]}}, respShifted[15:0]};
      2'd2:    loadData = {{(XLEN-32){~unsignedQ & respShifted[31]}}, respShifted[31:0]};
      default: loadData = respShifted;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= stateNext;
  end

  // Next-state logic
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: begin
        if (in_valid) begin
          if (misalignHit)               stateNext = DONE;
          else if (is_store || is_load)  stateNext = REQ;
          else                           stateNext = DONE;
        end
      end
      REQ:     if (mem_req_ready)  stateNext = isStoreQ ? DONE : WAIT;
      WAIT:    if (mem_resp_valid) stateNext = DONE;
      default: if (out_ready)      stateNext = IDLE;
    endcase
  end

  // Operation latch at accept and load-result capture in WAIT
  always_ff @(posedge clk) begin
    if (rst) begin
      addrQ     <= '0;
      wdataQ    <= '0;
      wmaskQ    <= '0;
      rdataQ    <= '0;
      isStoreQ  <= 1'b0;
      sizeQ     <= '0;
      unsignedQ <= 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
      misalignQ <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            addrQ     <= addr;
            sizeQ     <= size;
            unsignedQ <= load_unsigned;
            isStoreQ  <= is_store;
            wdataQ    <= is_store ? storeData : '0;
            wmaskQ    <= is_store ? maskWide[7:0] : '0;
            rdataQ    <= '0;
`ifdef LSU_MISALIGN_CHECK_EN
            misalignQ <= misalignHit;
`endif
          end
        end
        WAIT:    if (mem_resp_valid) rdataQ <= loadData;
        default: ;
      endcase
    end
  end

  assign in_ready      = (state == IDLE);
  assign mem_req_valid = (state == REQ);
  assign out_valid     = (state == DONE);
  assign mem_req_addr  = {addrQ[XLEN-1:3], 3'b000};
  assign mem_req_wen   = isStoreQ;
  assign mem_req_wdata = wdataQ;
  assign mem_req_wmask = wmaskQ;
  assign out_rdata     = rdataQ;

endmodule

// File: tb/tb_lsu_stage.sv
// Directed self-checking bench for lsu_stage.
module tb_lsu_stage;
  localparam int unsigned XLEN = 64;

  logic            clk = 1'b0;
  logic            rst;
  logic            inValid, inReady;
  logic [XLEN-1:0] addr, wdata;
  logic            isLoad, isStore, loadUnsigned;
  logic [1:0]      size;
  logic            memReqValid, memReqReady, memReqWen;
  logic [XLEN-1:0] memReqAddr, memReqWdata;
  logic [7:0]      memReqWmask;
  logic            memRespValid;
  logic [XLEN-1:0] memRespRdata;
  logic            outValid, outReady, outMisalign;
  logic [XLEN-1:0] outRdata;

  int passCnt = 0;
  int totalCnt = 0;

  lsu_stage #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst),
    .in_valid(inValid), .in_ready(inReady),
    .addr(addr), .wdata(wdata), .is_load(isLoad), .is_store(isStore),
    .size(size), .load_unsigned(loadUnsigned),
    .mem_req_valid(memReqValid), .mem_req_ready(memReqReady),
    .mem_req_addr(memReqAddr), .mem_req_wen(memReqWen),
    .mem_req_wdata(memReqWdata), .mem_req_wmask(memReqWmask),
    .mem_resp_valid(memRespValid), .mem_resp_rdata(memRespRdata),
    .out_valid(outValid), .out_ready(outReady),
    .out_rdata(outRdata), .out_misalign(outMisalign)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    inValid = 0; isLoad = 0; isStore = 0; loadUnsigned = 0; size = 0;
    memReqReady = 0; memRespValid = 0; outReady = 0;
  endtask

  task automatic test_reset();
    rst = 1; inValid = 1; isLoad = 1; addr = 64'h1234_5678; size = 2'd3;
    memReqReady = 0; memRespValid = 0; outReady = 0; wdata = '0; memRespRdata = '0;
    tick(); tick();
    quiet();
    totalCnt++; if (inReady !== 1'b1) $display("FAIL reset in_ready got %b exp 1", inReady); else passCnt++;
    totalCnt++; if (memReqValid !== 1'b0) $display("FAIL reset mem_req_valid got %b exp 0", memReqValid); else passCnt++;
    totalCnt++; if (outValid !== 1'b0) $display("FAIL reset out_valid got %b exp 0", outValid); else passCnt++;
    totalCnt++; if (memReqAddr !== 64'h0) $display("FAIL reset mem_req_addr got %h exp 0", memReqAddr); else passCnt++;
    totalCnt++; if ({memReqWen, memReqWmask} !== 9'h0) $display("FAIL reset wen/wmask got %b/%h exp 0/00", memReqWen, memReqWmask); else passCnt++;
    totalCnt++; if (outRdata !== 64'h0) $display("FAIL reset out_rdata got %h exp 0", outRdata); else passCnt++;
    totalCnt++; if (outMisalign !== 1'b0) $display("FAIL reset out_misalign got %b exp 0", outMisalign); else passCnt++;
    rst = 0;
    tick();
  endtask

  task automatic test_load_sign();
    quiet();
    inValid = 1; isLoad = 1; size = 2'd0; loadUnsigned = 0; addr = 64'h8000_0003; memReqReady = 1;
    tick(); // accept -> REQ
    inValid = 0;
    totalCnt++; if (memReqValid !== 1'b1) $display("FAIL ldb req_valid got %b exp 1", memReqValid); else passCnt++;
    totalCnt++; if (memReqAddr !== 64'h8000_0000) $display("FAIL ldb req_addr got %h exp 0000000080000000", memReqAddr); else passCnt++;
    totalCnt++; if ({memReqWen, memReqWmask, memReqWdata} !== 73'h0) $display("FAIL ldb store ctl got %b %h %h exp 0", memReqWen, memReqWmask, memReqWdata); else passCnt++;
    tick(); // handshake -> WAIT
    memReqReady = 0; memRespValid = 1; memRespRdata = 64'h0000_0000_8000_0000;
    totalCnt++; if (outValid !== 1'b0) $display("FAIL ldb early out_valid got %b exp 0", outValid); else passCnt++;
    tick(); // response -> DONE, third edge from accept
    memRespValid = 0;
    totalCnt++; if (outValid !== 1'b1) $display("FAIL ldb latency out_valid got %b exp 1", outValid); else passCnt++;
    totalCnt++; if (outRdata !== 64'hFFFF_FFFF_FFFF_FF80) $display("FAIL ldb rdata got %h exp ffffffffffffff80", outRdata); else passCnt++;
    outReady = 1;
    tick();
    outReady = 0;
    totalCnt++; if (inReady !== 1'b1 || outValid !== 1'b0) $display("FAIL ldb return in_ready/out_valid got %b/%b exp 1/0", inReady, outValid); else passCnt++;
  endtask

  task automatic test_store_half();
    quiet();
    inValid = 1; isStore = 1; isLoad = 1; size = 2'd1; addr = 64'h8000_0006; wdata = 64'h1234; memReqReady = 1;
    tick();
    inValid = 0;
    totalCnt++; if (memReqValid !== 1'b1 || memReqWen !== 1'b1) $display("FAIL sth valid/wen got %b/%b exp 1/1", memReqValid, memReqWen); else passCnt++;
    totalCnt++; if (memReqWmask !== 8'hC0) $display("FAIL sth wmask got %h exp c0", memReqWmask); else passCnt++;
    totalCnt++; if (memReqWdata !== 64'h1234_0000_0000_0000) $display("FAIL sth wdata got %h exp 1234000000000000", memReqWdata); else passCnt++;
    totalCnt++; if (memReqAddr !== 64'h8000_0000) $display("FAIL sth req_addr got %h exp 0000000080000000", memReqAddr); else passCnt++;
    tick();
    memReqReady = 0;
    totalCnt++; if (outValid !== 1'b1) $display("FAIL sth latency out_valid got %b exp 1", outValid); else passCnt++;
    totalCnt++; if (outRdata !== 64'h0) $display("FAIL sth out_rdata got %h exp 0", outRdata); else passCnt++;
    outReady = 1;
    tick();
    outReady = 0;
  endtask

  task automatic test_load_stall();
    int ovCount = 0;
    quiet();
    inValid = 1; isLoad = 1; size = 2'd3; addr = 64'h1000;
    tick();
    inValid = 0; memRespValid = 1; memRespRdata = 64'hBAD;
    for (int i = 0; i < 3; i++) begin
      if (outValid) ovCount++;
      totalCnt++; if (memReqValid !== 1'b1 || memReqAddr !== 64'h1000 || memReqWen !== 1'b0) $display("FAIL stall req hold cyc %0d got %b %h %b exp 1 1000 0", i, memReqValid, memReqAddr, memReqWen); else passCnt++;
      tick();
    end
    memReqReady = 1; memRespValid = 0;
    tick(); // handshake -> WAIT
    if (outValid) ovCount++;
    memReqReady = 0;
    totalCnt++; if (memReqValid !== 1'b0) $display("FAIL stall req drop got %b exp 0", memReqValid); else passCnt++;
    tick();
    if (outValid) ovCount++;
    memRespValid = 1; memRespRdata = 64'h1122_3344_5566_7788;
    tick();
    memRespValid = 0;
    if (outValid) ovCount++;
    totalCnt++; if (outRdata !== 64'h1122_3344_5566_7788) $display("FAIL stall rdata got %h exp 1122334455667788", outRdata); else passCnt++;
    outReady = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (outValid) ovCount++;
    end
    outReady = 0;
    totalCnt++; if (ovCount !== 1) $display("FAIL stall out_valid count got %0d exp 1", ovCount); else passCnt++;
  endtask

  task automatic test_out_hold();
    quiet();
    inValid = 1; isLoad = 1; size = 2'd2; loadUnsigned = 1; addr = 64'h2004; memReqReady = 1;
    tick();
    inValid = 0;
    tick();
    memReqReady = 0; memRespValid = 1; memRespRdata = 64'hDEAD_BEEF_0000_0000;
    tick();
    memRespValid = 0;
    inValid = 1; isStore = 1; isLoad = 0; addr = 64'h10;
    for (int i = 0; i < 4; i++) begin
      totalCnt++; if (outValid !== 1'b1 || outRdata !== 64'h0000_0000_DEAD_BEEF || inReady !== 1'b0) $display("FAIL hold cyc %0d got v=%b d=%h rdy=%b exp 1 00000000deadbeef 0", i, outValid, outRdata, inReady); else passCnt++;
      tick();
    end
    outReady = 1;
    tick();
    inValid = 0; outReady = 0;
    totalCnt++; if (inReady !== 1'b1 || outValid !== 1'b0) $display("FAIL hold release in_ready/out_valid got %b/%b exp 1/0", inReady, outValid); else passCnt++;
  endtask

  task automatic test_reset_wait();
    int ovCount = 0;
    quiet();
    inValid = 1; isLoad = 1; size = 2'd3; addr = 64'h3000; memReqReady = 1;
    tick();
    inValid = 0;
    tick(); // WAIT
    memReqReady = 0; rst = 1; memRespValid = 1; memRespRdata = '1;
    tick();
    rst = 0;
    totalCnt++; if (inReady !== 1'b1 || memReqValid !== 1'b0 || outValid !== 1'b0) $display("FAIL rstwait state got rdy=%b req=%b ov=%b exp 1 0 0", inReady, memReqValid, outValid); else passCnt++;
    for (int i = 0; i < 3; i++) begin
      tick();
      if (outValid) ovCount++;
    end
    memRespValid = 0;
    totalCnt++; if (ovCount !== 0 || outRdata !== 64'h0) $display("FAIL rstwait leak got count=%0d d=%h exp 0 0", ovCount, outRdata); else passCnt++;
    inValid = 1; isStore = 1; addr = 64'h40;
    tick(); // REQ, ready withheld
    inValid = 0; isStore = 0;
    rst = 1;
    tick();
    rst = 0;
    totalCnt++; if (memReqValid !== 1'b0 || inReady !== 1'b1) $display("FAIL rstreq drop got req=%b rdy=%b exp 0 1", memReqValid, inReady); else passCnt++;
  endtask

  task automatic test_back_to_back();
    quiet();
    inValid = 1; addr = 64'h55; memRespValid = 1; memRespRdata = 64'h77;
    tick(); // neither kind -> DONE
    memRespValid = 0;
    totalCnt++; if (outValid !== 1'b1 || outRdata !== 64'h0 || memReqValid !== 1'b0) $display("FAIL noop got v=%b d=%h req=%b exp 1 0 0", outValid, outRdata, memReqValid); else passCnt++;
    isStore = 1; size = 2'd0; addr = 64'h3; wdata = 64'hAB; memReqReady = 1; outReady = 1;
    tick(); // DONE -> IDLE
    totalCnt++; if (inReady !== 1'b1) $display("FAIL b2b in_ready got %b exp 1", inReady); else passCnt++;
    tick(); // accept
    inValid = 0;
    totalCnt++; if (memReqWmask !== 8'h08 || memReqWdata !== 64'hAB00_0000) $display("FAIL b2b store got m=%h d=%h exp 08 00000000ab000000", memReqWmask, memReqWdata); else passCnt++;
    tick();
    totalCnt++; if (outValid !== 1'b1) $display("FAIL b2b out_valid got %b exp 1", outValid); else passCnt++;
    tick();
    quiet();
  endtask

  task automatic test_misalign();
    quiet();
`ifdef LSU_MISALIGN_CHECK_EN
    inValid = 1; isLoad = 1; size = 2'd2; addr = 64'h8000_0002; memReqReady = 1;
    tick();
    inValid = 0;
    totalCnt++; if (outValid !== 1'b1 || outMisalign !== 1'b1) $display("FAIL mis flag got v=%b m=%b exp 1 1", outValid, outMisalign); else passCnt++;
    totalCnt++; if (memReqValid !== 1'b0 || outRdata !== 64'h0) $display("FAIL mis nomem got req=%b d=%h exp 0 0", memReqValid, outRdata); else passCnt++;
`else
    inValid = 1; isStore = 1; size = 2'd3; addr = 64'h8000_0004; wdata = 64'h0102_0304_0506_0708; memReqReady = 1;
    tick();
    inValid = 0;
    totalCnt++; if (memReqValid !== 1'b1 || memReqWmask !== 8'hF0) $display("FAIL mis mask got v=%b m=%h exp 1 f0", memReqValid, memReqWmask); else passCnt++;
    totalCnt++; if (memReqWdata !== 64'h0506_0708_0000_0000) $display("FAIL mis wdata got %h exp 0506070800000000", memReqWdata); else passCnt++;
    tick();
    totalCnt++; if (outValid !== 1'b1 || outMisalign !== 1'b0) $display("FAIL mis tie got v=%b m=%b exp 1 0", outValid, outMisalign); else passCnt++;
`endif
    outReady = 1;
    tick();
    quiet();
  endtask

  initial begin
    test_reset();
    test_load_sign();
    test_store_half();
    test_load_stall();
    test_out_hold();
    test_reset_wait();
    test_back_to_back();
    test_misalign();
    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout got running exp finished");
    $fatal(1, "timeout");
  end
endmodule
